// File: rtl/seg7_scan8.sv
// Eight-digit multiplexed hex display scanner.
// Left four digits show DataHi, right four show DataLo. Values are staged on
// Load and committed to the displayed (shadow) copy only at the frame boundary
// (digit 7 -> 0 advance), so a scan never mixes two values. Each digit slot
// opens with GHOST blank cycles to suppress ghosting while the digit enables
// switch. Optional leading-zero blanking works independently per 4-digit half.
// Outputs depend only on registered state plus the reset level; there is no
// combinational path from DataHi/DataLo/Load to the display pins.

module seg7_scan8 #(
    parameter int REFRESH_DIV = 100000,
    parameter int GHOST       = 2,
    parameter int BLANK_LZ    = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] DataHi,
    input  logic [15:0] DataLo,
    input  logic        Load,
    output logic [6:0]  out7,
    output logic [7:0]  en_out,
    output logic [2:0]  DigitIdx
);

    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [PW-1:0] SLOT_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [PW-1:0] GHOST_CNT = PW'(GHOST);

    logic [PW-1:0] prescaler;
    logic [2:0]    digit;
    logic [31:0]   staging;
    logic [31:0]   shadow;
    logic          pending;

    logic          slot_end;
    logic          frame_end;
    logic [31:0]   data_in;

    logic [3:0]    nibble;
    logic [15:0]   half_val;
    logic [1:0]    pos_in_half;
    logic          ghost_blank;
    logic          lz_blank;
    logic [6:0]    seg_code;

    assign data_in   = {DataHi, DataLo};
    assign slot_end  = (prescaler == SLOT_LAST);
    assign frame_end = slot_end && (digit == 3'd7);

    // Hex nibble to active-low {g,f,e,d,c,b,a} segment pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0:    seg = 7'b1000000;
            4'h1:    seg = 7'b1111001;
            4'h2:    seg = 7'b0100100;
            4'h3:    seg = 7'b0110000;
            4'h4:    seg = 7'b0011001;
            4'h5:    seg = 7'b0010010;
            4'h6:    seg = 7'b0000010;
            4'h7:    seg = 7'b1111000;
            4'h8:    seg = 7'b0000000;
            4'h9:    seg = 7'b0010000;
            4'hA:    seg = 7'b0001000;
            4'hB:    seg = 7'b0000011;
            4'hC:    seg = 7'b1000110;
            4'hD:    seg = 7'b0100001;
            4'hE:    seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    // Slot timer and digit scan counter; digit advances when the slot expires.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            prescaler <= '0;
            digit     <= 3'd0;
        end else if (slot_end) begin
            prescaler <= '0;
            digit     <= digit + 3'd1;
        end else begin
            prescaler <= prescaler + PW'(1);
        end
    end

    // Staging capture and frame-boundary commit. A Load coinciding with the
    // boundary wins over any older staged value and leaves nothing pending.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            staging <= 32'h0;
            shadow  <= 32'h0;
            pending <= 1'b0;
        end else begin
            if (Load) begin
                staging <= data_in;
            end
            if (frame_end) begin
                if (Load) begin
                    shadow <= data_in;
                end else if (pending) begin
                    shadow <= staging;
                end
                pending <= 1'b0;
            end else if (Load) begin
                pending <= 1'b1;
            end
        end
    end

    // Blanking decisions: ghost window at slot start, and leading zeros when
    // this digit and every more-significant digit of its half are zero.
    always_comb begin
        nibble      = shadow[{digit, 2'b00} +: 4];
        half_val    = digit[2] ? shadow[31:16] : shadow[15:0];
        pos_in_half = digit[1:0];
        ghost_blank = (prescaler < GHOST_CNT);
        lz_blank    = (BLANK_LZ != 0) && (pos_in_half != 2'd0) &&
                      ((half_val >> {pos_in_half, 2'b00}) == 16'h0000);
        seg_code    = hex_to_seg(nibble);
    end

    // Display drive; everything is forced blank while reset is held.
    always_comb begin
        en_out   = 8'hFF;
        out7     = 7'h7F;
        DigitIdx = digit;
        if (!Reset) begin
            DigitIdx = 3'd0;
        end else if (!ghost_blank && !lz_blank) begin
            en_out = ~(8'b0000_0001 << digit);
            out7   = seg_code;
        end
    end

endmodule

// File: doc/seg7_scan8.md
Name: seg7_scan8

Overview:
Eight-digit multiplexed hex display scanner for the board's 7-segment bank, downstream of the motion-estimation datapath. Shows two 16-bit values: left four digits DataHi, right four digits DataLo (e.g. Y and X best-match coordinates). Load requests are staged and committed only at frame boundaries, so a display frame never tears mid-scan. Adds per-digit anti-ghost blanking and optional leading-zero blanking.

Parameters:
REFRESH_DIV, 100000, Clk cycles per digit slot (≥2).
GHOST, 2, blank cycles at start of each slot (0 ≤ GHOST < REFRESH_DIV).
BLANK_LZ, 0, 1 = blank leading zeros within each 4-digit half.

Ports:
Clk  in  1  system clock.
Reset  in  1  synchronous active-low reset.
DataHi  in  16  value for digits 7..4 (digit 7 = DataHi[15:12]).
DataLo  in  16  value for digits 3..0 (digit 0 = DataLo[3:0]).
Load  in  1  capture DataHi/DataLo into staging; tie high for continuous update.
out7  out  7  active-low segments {g,f,e,d,c,b,a}.
en_out  out  8  active-low digit enables; en_out[0] = rightmost digit.
DigitIdx  out  3  current digit slot.

Behaviour:
- One clock, Clk. Reset is synchronous and active-low; all state updates on the rising Clk edge.
- State registers: prescaler (0..REFRESH_DIV-1), digit (3 bit), staging (32), shadow (32), pending (1).
- Reset (Reset=0 at an edge) clears all state to 0. While Reset=0, outputs are forced blank: en_out=8'hFF, out7=7'h7F, DigitIdx=0.
- Prescaler increments each cycle. At REFRESH_DIV-1 it wraps to 0 and digit increments; 7 wraps to 0. The 7->0 advance is the frame boundary.
- Load=1: staging <= {DataHi,DataLo} and pending <= 1 on that edge.
- At a frame-boundary edge with pending=1 and Load=0: shadow <= staging and pending <= 0.
- At a frame-boundary edge with Load=1: shadow <= current {DataHi,DataLo}, staging is also updated, and pending <= 0.
- Outputs are combinational from registered state only, with no combinational path from the data inputs.
- Blank condition: prescaler < GHOST, or the digit is leading-zero blanked. When blank: en_out=8'hFF and out7=7'h7F.
- When not blank: en_out = ~(1<<digit), and out7 = decode of shadow nibble[digit*4+3 : digit*4].
- DigitIdx = digit at all times out of reset.
- Decode table (hex -> out7):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000
  - 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011
  - C=1000110, d=0100001, E=0000110, F=0001110
- BLANK_LZ=1: within each half (digits 3..0, 7..4), a digit is blanked if it and every more-significant digit in its half are zero. Digits 0 and 4 are never LZ-blanked.
- Full frame = 8*REFRESH_DIV cycles. Shadow changes only at a frame boundary.
- Reset mid-frame discards staging and pending. The display restarts at digit 0 with value 0.

Test Plan:
- REFRESH_DIV=4, GHOST=1. Reset low 2 cycles, then high; shadow=0 -> each slot shows 1 blank cycle (en_out=FF), then 3 cycles of en_out=FE, FD, ... 7F with out7=1000000.
- Load pulse with DataHi=16'h1234, DataLo=16'hABCD mid-frame (digit 3) -> remainder of frame still shows 0. Next frame: digit0=0100001 (d), digit4=0011001 (4), digit7=1111001 (1).
- Load held high with input changing every cycle -> shadow equals the input sampled at the exact 7->0 edge. Digit values stay constant within the frame.
- Load asserted exactly on a frame-boundary edge with prior pending value 16'h0000_0001 -> shadow takes the Load-cycle input, not the staged one, and pending clears.
- BLANK_LZ=1, value Hi=16'h0005, Lo=16'h0000 -> en_out active only for digits 4 and 0. out7 = 0010010 on digit 4 and 1000000 on digit 0; digits 1–3 and 5–7 stay FF.
- Reset driven low during digit 5 after a loaded value -> next edge gives en_out=FF and DigitIdx=0. After release, displays 0 with no pending commit.
